// File: rtl/data_merger_if.sv
// data_merger_if
//   Groups the two show-ahead source channels and the push-style sink of
//   data_merger into one bundle.
//   master : the merger side (drives pops and push, receives rdy/data).
//   slave  : the environment side (sources and sink).
//   Signals: idata1_rdy/idata1/idata1_pop  channel 1 source
//            idata2_rdy/idata2/idata2_pop  channel 2 source
//            odata_rdy/odata_push/odata    output sink
//   Optional build macro DATA_MERGER_TAG_EN adds odata_chan (source tag).
interface data_merger_if #(
   parameter int unsigned DW = 32
);
   logic          idata1_rdy;
   logic [DW-1:0] idata1;
   logic          idata1_pop;
   logic          idata2_rdy;
   logic [DW-1:0] idata2;
   logic          idata2_pop;
   logic          odata_rdy;
   logic          odata_push;
   logic [DW-1:0] odata;
`ifdef DATA_MERGER_TAG_EN
   logic          odata_chan;
`endif

   modport master (
      input  idata1_rdy, idata1,
      output idata1_pop,
      input  idata2_rdy, idata2,
      output idata2_pop,
      input  odata_rdy,
      output odata_push, odata
`ifdef DATA_MERGER_TAG_EN
      , output odata_chan
`endif
   );

   modport slave (
      output idata1_rdy, idata1,
      input  idata1_pop,
      output idata2_rdy, idata2,
      input  idata2_pop,
      output odata_rdy,
      input  odata_push, odata
`ifdef DATA_MERGER_TAG_EN
      , input odata_chan
`endif
   );
endinterface

// File: rtl/data_merger.sv
// data_merger
//   Re-assembles a split stream: takes stagecnt words from channel 1, then
//   num words from channel 2, forever, and pushes them through a single
//   output hold register.
//   Ports: clk       system clock
//          rst       synchronous active-high reset
//          stagecnt  words per round from channel 1 (sampled in IDLE)
//          num       words per round from channel 2 (sampled in IDLE)
//          bus       data_merger_if.master (sources + sink)
//   Optional build macro DATA_MERGER_TAG_EN: adds bus.odata_chan, 0 for
//   channel 1 words and 1 for channel 2 words.
module data_merger #(
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [CW-1:0]  stagecnt,
   input  logic [CW-1:0]  num,
   data_merger_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CH1  = 2'd1,
      CH2  = 2'd2
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [CW-1:0] r_s_lat, r_n_lat;
   logic          r_hold_vld;
   logic [DW-1:0] r_hold_data;
   logic          w_pop_ok, w_pop1, w_pop2, w_push;
`ifdef DATA_MERGER_TAG_EN
   logic          r_hold_chan;
`endif

   // The hold slot can take a new word if it is empty or is being drained now.
   assign w_pop_ok  = !r_hold_vld || bus.odata_rdy;
   assign w_cnt_inc = r_cnt + CW'(1);
   // Handshakes are suppressed in the reset cycle so no source word is lost.
   assign w_push    = r_hold_vld && bus.odata_rdy && !rst;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop1      = 1'b0;
      w_pop2      = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            // Decision uses the counts being latched this same cycle.
            if (stagecnt != '0)
               w_state_nxt = CH1;
            else if (num != '0)
               w_state_nxt = CH2;
         end
         CH1: begin
            if (bus.idata1_rdy && w_pop_ok) begin
               w_pop1 = 1'b1;
               if (w_cnt_inc == r_s_lat) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = (r_n_lat != '0) ? CH2 : IDLE;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
         end
         CH2: begin
            if (bus.idata2_rdy && w_pop_ok) begin
               w_pop2 = 1'b1;
               if (w_cnt_inc == r_n_lat) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (rst) begin
         w_pop1 = 1'b0;
         w_pop2 = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_s_lat     <= '0;
         r_n_lat     <= '0;
         r_hold_vld  <= 1'b0;
         r_hold_data <= '0;
`ifdef DATA_MERGER_TAG_EN
         r_hold_chan <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (r_state == IDLE) begin
            r_s_lat <= stagecnt;
            r_n_lat <= num;
         end
         // A refill in the same cycle as a push keeps the slot occupied.
         if (w_pop1 || w_pop2) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= w_pop1 ? bus.idata1 : bus.idata2;
`ifdef DATA_MERGER_TAG_EN
            r_hold_chan <= w_pop2;
`endif
         end else if (w_push) begin
            r_hold_vld <= 1'b0;
         end
      end
   end

   assign bus.idata1_pop = w_pop1;
   assign bus.idata2_pop = w_pop2;
   assign bus.odata_push = w_push;
   assign bus.odata      = r_hold_data;
`ifdef DATA_MERGER_TAG_EN
   assign bus.odata_chan = r_hold_chan;
`endif

endmodule

// File: tb/tb_data_merger.sv
// tb_data_merger
//   Self-checking bench for data_merger. Sources are modelled as queues with
//   show-ahead heads, the sink records every pushed word. The expected output
//   stream is derived from the source contents and the round rule
//   (stagecnt from channel 1, then num from channel 2, repeated).
//   Honours DATA_MERGER_TAG_EN by also checking odata_chan.
module tb_data_merger;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 32;

   typedef struct packed {
      logic          chan;
      logic [DW-1:0] data;
   } word_t;

   typedef struct {
      int unsigned s, n, na, nb, cycles, e_push, e_pop1, e_pop2;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CW-1:0] stagecnt = '0;
   logic [CW-1:0] num = '0;

   data_merger_if #(.DW(DW)) bus ();

   data_merger #(.DW(DW), .CW(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .stagecnt (stagecnt),
      .num      (num),
      .bus      (bus)
   );

   logic [DW-1:0] q1[$], q2[$];
   word_t         out_q[$], exp_q[$];
   logic          en1 = 1'b1, en2 = 1'b1;
   logic          h1_vld = 1'b0, h2_vld = 1'b0;
   logic [DW-1:0] h1_dat = '0, h2_dat = '0;
   logic          s_pop1 = 1'b0, s_pop2 = 1'b0;
   int unsigned   n_pop1 = 0, n_pop2 = 0, n_push = 0;
   int            vectors = 0, miscompares = 0;
   vec_t          tbl[6];

   assign bus.idata1_rdy = en1 & h1_vld;
   assign bus.idata1     = h1_dat;
   assign bus.idata2_rdy = en2 & h2_vld;
   assign bus.idata2     = h2_dat;

   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Sample away from the active edge; protocol rules checked every cycle.
   always @(negedge clk) begin
      s_pop1 = bus.idata1_pop;
      s_pop2 = bus.idata2_pop;
      if (!rst) begin
         chk("pop1_without_rdy", 64'(bus.idata1_pop & ~bus.idata1_rdy), 64'd0);
         chk("pop2_without_rdy", 64'(bus.idata2_pop & ~bus.idata2_rdy), 64'd0);
         chk("dual_pop", 64'(bus.idata1_pop & bus.idata2_pop), 64'd0);
         chk("push_without_rdy", 64'(bus.odata_push & ~bus.odata_rdy), 64'd0);
         if (bus.idata1_pop) n_pop1++;
         if (bus.idata2_pop) n_pop2++;
         if (bus.odata_push) begin
            n_push++;
`ifdef DATA_MERGER_TAG_EN
            out_q.push_back({bus.odata_chan, bus.odata});
`else
            out_q.push_back({1'b0, bus.odata});
`endif
         end
      end
   end

   // Source FIFOs: consume on pop, present the new head after the edge.
   always @(posedge clk) begin
      if (s_pop1 && q1.size() != 0) void'(q1.pop_front());
      if (s_pop2 && q2.size() != 0) void'(q2.pop_front());
      if (q1.size() != 0) begin h1_vld <= 1'b1; h1_dat <= q1[0]; end
      else begin h1_vld <= 1'b0; h1_dat <= '0; end
      if (q2.size() != 0) begin h2_vld <= 1'b1; h2_dat <= q2[0]; end
      else begin h2_vld <= 1'b0; h2_dat <= '0; end
   end

   // Reference: interleave current source contents in rounds of s then n
   // words, stopping where the next needed word does not exist.
   function automatic void build_exp(int unsigned s, int unsigned n);
      logic [DW-1:0] a[$], b[$];
      a = q1;
      b = q2;
      exp_q.delete();
      if (s == 0 && n == 0) return;
      while (1) begin
         for (int unsigned i = 0; i < s; i++) begin
            if (a.size() == 0) return;
            exp_q.push_back({1'b0, a.pop_front()});
         end
         for (int unsigned i = 0; i < n; i++) begin
            if (b.size() == 0) return;
            exp_q.push_back({1'b1, b.pop_front()});
         end
      end
   endfunction

   task automatic check_order(string name);
      for (int i = 0; i < out_q.size(); i++) begin
         if (i < exp_q.size()) begin
            chk($sformatf("%s_word%0d", name, i), 64'(out_q[i].data), 64'(exp_q[i].data));
`ifdef DATA_MERGER_TAG_EN
            chk($sformatf("%s_chan%0d", name, i), 64'(out_q[i].chan), 64'(exp_q[i].chan));
`endif
         end else begin
            chk($sformatf("%s_extra_word_index", name), 64'(i), 64'(exp_q.size()));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(int unsigned s, int unsigned n, int unsigned na, int unsigned nb, bit rnd);
      rst = 1'b1;
      stagecnt = s;
      num = n;
      en1 = 1'b1;
      en2 = 1'b1;
      bus.odata_rdy = 1'b1;
      q1.delete();
      q2.delete();
      for (int unsigned i = 0; i < na; i++) q1.push_back(rnd ? $urandom : 32'hA000_0000 + i + 1);
      for (int unsigned i = 0; i < nb; i++) q2.push_back(rnd ? $urandom : 32'hB000_0000 + i + 1);
      tick();
      tick();
      build_exp(s, n);
      out_q.delete();
      n_pop1 = 0;
      n_pop2 = 0;
      n_push = 0;
      rst = 1'b0;
   endtask

   initial begin
      bus.odata_rdy = 1'b1;
      //         s  n  na nb cyc push pop1 pop2
      tbl[0] = '{2, 3, 4, 6, 14, 10, 4, 6};
      tbl[1] = '{1, 1, 3, 3,  8,  4, 3, 2};
      tbl[2] = '{0, 2, 2, 4,  7,  4, 0, 4};
      tbl[3] = '{3, 0, 6, 2,  9,  6, 6, 0};
      tbl[4] = '{5, 2, 3, 5, 10,  3, 3, 0};
      tbl[5] = '{0, 0, 2, 2, 20,  0, 0, 0};

      // Reset state before any traffic.
      tick();
      tick();
      @(negedge clk); #1;
      chk("reset_pop1", 64'(bus.idata1_pop), 64'd0);
      chk("reset_pop2", 64'(bus.idata2_pop), 64'd0);
      chk("reset_push", 64'(bus.odata_push), 64'd0);
      chk("reset_odata", 64'(bus.odata), 64'd0);

      for (int i = 0; i < 6; i++) begin
         start(tbl[i].s, tbl[i].n, tbl[i].na, tbl[i].nb, 1'b0);
         repeat (tbl[i].cycles) tick();
         chk($sformatf("row%0d_pushes", i), 64'(n_push), 64'(tbl[i].e_push));
         chk($sformatf("row%0d_pops1", i), 64'(n_pop1), 64'(tbl[i].e_pop1));
         chk($sformatf("row%0d_pops2", i), 64'(n_pop2), 64'(tbl[i].e_pop2));
         check_order($sformatf("row%0d", i));
      end

      // Leaving the all-zero counts: the idle round picks up 1/1.
      stagecnt = 1;
      num = 1;
      build_exp(1, 1);
      out_q.delete();
      n_push = 0;
      repeat (8) tick();
      chk("zero_switch_pushes", 64'(n_push), 64'd4);
      check_order("zero_switch");

      // Channel 2 stalls after A1; channel 1 must not be popped meanwhile.
      start(1, 2, 3, 4, 1'b0);
      en2 = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("stall_no_pop1", 64'(bus.idata1_pop), 64'd0);
         chk("stall_no_pop2", 64'(bus.idata2_pop), 64'd0);
         tick();
      end
      en2 = 1'b1;
      repeat (12) tick();
      chk("stall_pops1", 64'(n_pop1), 64'd3);
      chk("stall_pops2", 64'(n_pop2), 64'd4);
      check_order("src_stall");

      // Sink backpressure with A2 in the hold register.
      start(2, 3, 4, 6, 1'b0);
      repeat (3) tick();
      bus.odata_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("bp_odata_stable", 64'(bus.odata), 64'h0000_0000_A000_0002);
         chk("bp_no_push", 64'(bus.odata_push), 64'd0);
         chk("bp_no_pop", 64'(bus.idata1_pop | bus.idata2_pop), 64'd0);
         tick();
      end
      bus.odata_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("bp_release_push", 64'(bus.odata_push), 64'd1);
         tick();
      end
      repeat (10) tick();
      chk("bp_pushes", 64'(n_push), 64'd10);
      check_order("backpressure");

      // Reset right after the first word of a 3-word channel 1 round.
      start(3, 1, 6, 4, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      build_exp(3, 1);
      out_q.delete();
      n_pop1 = 0;
      n_pop2 = 0;
      n_push = 0;
      @(negedge clk); #1;
      chk("rst_odata", 64'(bus.odata), 64'd0);
      chk("rst_push", 64'(bus.odata_push), 64'd0);
      chk("rst_pop1", 64'(bus.idata1_pop), 64'd0);
      chk("rst_pop2", 64'(bus.idata2_pop), 64'd0);
      tick();
      repeat (4) tick();
      chk("rst_round_pops1", 64'(n_pop1), 64'd3);
      chk("rst_round_pops2", 64'(n_pop2), 64'd1);
      repeat (10) tick();
      check_order("mid_reset");

      // Randomised traffic, then a fully-ready drain.
      for (int t = 0; t < 4; t++) begin
         int unsigned s, n;
         s = $urandom_range(0, 3);
         n = $urandom_range(0, 3);
         if (s == 0 && n == 0) n = 1;
         start(s, n, 40, 40, 1'b1);
         repeat (200) begin
            tick();
            en1 = ($urandom_range(0, 3) != 0);
            en2 = ($urandom_range(0, 3) != 0);
            bus.odata_rdy = ($urandom_range(0, 3) != 0);
         end
         en1 = 1'b1;
         en2 = 1'b1;
         bus.odata_rdy = 1'b1;
         repeat (200) tick();
         chk($sformatf("rand%0d_pushes", t), 64'(n_push), 64'(exp_q.size()));
         chk($sformatf("rand%0d_pops", t), 64'(n_pop1 + n_pop2), 64'(exp_q.size()));
         check_order($sformatf("rand%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
